// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and memory.
// The request side holds req/addr until ack; rdata is valid in the ack cycle.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding word request, a single-entry
// instruction register toward decode, and redirect handling that never withdraws a request.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_ctrl_if.master        imem,
  input  logic [31:0]         pred_pc,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                stall,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [31:0]         inst_pc,
  output logic [31:0]         pc_nb
);

  localparam logic [31:0] Nop       = 32'h0000_0013;
  localparam logic [31:0] ResetPcAl = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StValid,
    StFlush
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic [31:0] redirect_pc_al;
  logic [31:0] pred_pc_al;

  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
  assign pred_pc_al     = {pred_pc[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end

      StFetch: begin
        if (redirect) begin
          pc_d = redirect_pc_al;
          if (imem.imem_ack) begin
            // Response belongs to the wrong path: drop it and issue the new address.
            addr_d = redirect_pc_al;
          end else begin
            // Request stays up on the old address until memory answers it.
            state_d = StFlush;
          end
        end else if (imem.imem_ack) begin
          state_d   = StValid;
          req_d     = 1'b0;
          valid_d   = 1'b1;
          inst_d    = imem.imem_rdata;
          inst_pc_d = addr_q;
        end
      end

      StValid: begin
        if (redirect) begin
          state_d = StFetch;
          pc_d    = redirect_pc_al;
          req_d   = 1'b1;
          addr_d  = redirect_pc_al;
          valid_d = 1'b0;
        end else if (!stall) begin
          state_d = StFetch;
          pc_d    = pred_pc_al;
          req_d   = 1'b1;
          addr_d  = pred_pc_al;
          valid_d = 1'b0;
        end
      end

      StFlush: begin
        if (redirect) begin
          pc_d = redirect_pc_al;
        end
        // An ack coinciding with a redirect still retires the stale request,
        // otherwise FLUSH would wait for an ack that never comes.
        if (imem.imem_ack) begin
          state_d = StFetch;
          addr_d  = redirect ? redirect_pc_al : pc_q;
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= ResetPcAl;
      req_q     <= 1'b0;
      addr_q    <= ResetPcAl;
      valid_q   <= 1'b0;
      inst_q    <= Nop;
      inst_pc_q <= ResetPcAl;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign inst_valid     = valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc_nb          = inst_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change 1ns after each rising edge and
// outputs are checked at that same point, so each step shows one edge's effect.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_nb;

  int total;
  int bad;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus.master),
    .pred_pc    (pred_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .pc_nb      (pc_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    if (req) check({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    pred_pc        = '0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    #12;

    // Reset values
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_pc_nb", pc_nb, 32'h4);

    // First fetch, ack two cycles after the request appears
    rst_n = 1'b1;
    step();
    check_req("f0", 1'b1, 32'h0);
    check("f0_valid", {31'd0, inst_valid}, 32'd0);
    step();
    check_req("f0_hold", 1'b1, 32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    pred_pc        = 32'h4;
    stall          = 1'b1;
    step();
    check("v0_valid", {31'd0, inst_valid}, 32'd1);
    check("v0_inst", inst, 32'h0050_0093);
    check("v0_inst_pc", inst_pc, 32'h0);
    check("v0_pc_nb", pc_nb, 32'h4);
    check("v0_req", {31'd0, bus.imem_req}, 32'd0);

    // Stall three cycles; a stray ack in VALID must not disturb inst
    bus.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = (i == 1);
      step();
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_inst", inst, 32'h0050_0093);
      check("stall_inst_pc", inst_pc, 32'h0);
      check("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.imem_ack = 1'b0;
    stall        = 1'b0;
    step();
    check_req("f1", 1'b1, 32'h4);
    check("f1_valid", {31'd0, inst_valid}, 32'd0);

    // Fetch at 4, then redirect to 0x100 while stalled in VALID
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_AAAA;
    pred_pc        = 32'h8;
    stall          = 1'b1;
    step();
    check("v1_inst_pc", inst_pc, 32'h4);
    check("v1_pc_nb", pc_nb, 32'h8);
    bus.imem_ack = 1'b0;
    redirect     = 1'b1;
    redirect_pc  = 32'h100;
    step();
    check("rv_valid", {31'd0, inst_valid}, 32'd0);
    check_req("rv", 1'b1, 32'h100);
    redirect = 1'b0;

    // Fetch at 0x100, then move on to 0x8
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0113;
    step();
    check("v2_inst", inst, 32'h0000_0113);
    check("v2_inst_pc", inst_pc, 32'h100);
    check("v2_pc_nb", pc_nb, 32'h104);
    bus.imem_ack = 1'b0;
    stall        = 1'b0;
    step();
    check_req("f8", 1'b1, 32'h8);

    // Redirect with the 0x8 request outstanding: ack three cycles later is dropped
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check_req("fl_a", 1'b1, 32'h8);
    step();
    check_req("fl_b", 1'b1, 32'h8);
    step();
    check_req("fl_c", 1'b1, 32'h8);
    check("fl_valid", {31'd0, inst_valid}, 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0001;
    step();
    check_req("fl_done", 1'b1, 32'h200);
    check("fl_valid2", {31'd0, inst_valid}, 32'd0);
    bus.imem_ack = 1'b0;
    step();
    check_req("fl_hold", 1'b1, 32'h200);
    check("fl_inst", inst, 32'h0000_0113);

    // Two redirects while flushing: only the newest target is fetched
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    check_req("dr_a", 1'b1, 32'h200);
    redirect_pc = 32'h80;
    step();
    check_req("dr_b", 1'b1, 32'h200);
    redirect       = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0002;
    step();
    check_req("dr_done", 1'b1, 32'h80);
    check("dr_valid", {31'd0, inst_valid}, 32'd0);

    // Redirect coinciding with ack in FETCH: data dropped, new address next cycle
    redirect       = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    bus.imem_rdata = 32'hBAD0_0003;
    step();
    check_req("ra", 1'b1, 32'hFFFF_FFFC);
    check("ra_valid", {31'd0, inst_valid}, 32'd0);
    check("ra_inst", inst, 32'h0000_0113);

    // Fetch at the top of the address space, pc_nb wraps; misaligned redirect
    redirect       = 1'b0;
    bus.imem_rdata = 32'h1234_5678;
    stall          = 1'b1;
    step();
    check("wr_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wr_pc_nb", pc_nb, 32'h0);
    check("wr_inst", inst, 32'h1234_5678);
    bus.imem_ack = 1'b0;
    redirect     = 1'b1;
    redirect_pc  = 32'h103;
    step();
    check_req("al", 1'b1, 32'h100);
    redirect = 1'b0;
    stall    = 1'b0;

    // Asynchronous reset mid-transaction, then a stray ack around release
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req", {31'd0, bus.imem_req}, 32'd0);
    check("ar_addr", bus.imem_addr, 32'h0);
    check("ar_inst", inst, 32'h0000_0013);
    check("ar_valid", {31'd0, inst_valid}, 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0004;
    step();
    rst_n = 1'b1;
    step();
    check_req("ar_f", 1'b1, 32'h0);
    check("ar_f_valid", {31'd0, inst_valid}, 32'd0);
    bus.imem_ack = 1'b0;
    step();
    check_req("ar_f2", 1'b1, 32'h0);
    check("ar_f2_valid", {31'd0, inst_valid}, 32'd0);
    check("ar_f2_inst", inst, 32'h0000_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-005 imem_addr  output  32  SHALL be the request word address, with bits[1:0] = 0.
REQ-006 imem_ack  input  1  SHALL be the memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-008 pred_pc  input  32  SHALL be the predicted next PC, computed combinationally by decode from inst/inst_pc.
REQ-009 redirect  input  1  SHALL be the execute-stage mispredict/redirect strobe, one cycle.
REQ-010 redirect_pc  input  32  SHALL be the corrected PC, valid when redirect=1.
REQ-011 stall  input  1  SHALL be the downstream hold; when 1, the presented instruction is not consumed.
REQ-012 inst_valid  output  1  SHALL flag that inst/inst_pc hold a live instruction.
REQ-013 inst  output  32  SHALL be the registered fetched instruction.
REQ-014 inst_pc  output  32  SHALL be the address of inst.
REQ-015 pc_nb  output  32  SHALL equal inst_pc + 4, modulo 2^32.

Function
REQ-016 States SHALL be IDLE, FETCH, VALID and FLUSH, encoded in a registered state variable.
REQ-017 IDLE SHALL be entered only via reset and SHALL advance to FETCH unconditionally on the first clock edge after reset release.
REQ-018 FETCH SHALL drive imem_req=1 and imem_addr=pc_reg, both registered values.
REQ-019 Once imem_req=1, imem_req and imem_addr SHALL stay constant until the cycle imem_ack=1; requests are never withdrawn.
REQ-020 FETCH with imem_ack=1 and redirect=0 SHALL latch inst<=imem_rdata and inst_pc<=imem_addr, then enter VALID.
REQ-021 imem_req SHALL drop in the cycle after the ack; the minimum fetch-to-valid latency SHALL be 1 cycle after ack.
REQ-022 VALID SHALL drive inst_valid=1 and imem_req=0.
REQ-023 VALID with stall=1 SHALL hold inst, inst_pc and inst_valid unchanged.
REQ-024 VALID with stall=0 SHALL load pc_reg<=pred_pc and enter FETCH; inst_valid SHALL be 0 in the next cycle.
REQ-025 redirect SHALL have the highest priority over stall, ack and pred_pc in every state except IDLE.
REQ-026 redirect in VALID SHALL load pc_reg<=redirect_pc, enter FETCH and clear inst_valid next cycle.
REQ-027 redirect in FETCH with imem_ack=1 SHALL discard imem_rdata, load pc_reg<=redirect_pc and remain in FETCH with the new address next cycle.
REQ-028 redirect in FETCH with imem_ack=0 SHALL save redirect_pc into pc_reg, keep the outstanding request (old address), and enter FLUSH.
REQ-029 FLUSH SHALL keep imem_req=1 on the old address and, on imem_ack, discard the data and enter FETCH with pc_reg.
REQ-030 redirect in FLUSH SHALL overwrite pc_reg with the newest redirect_pc and stay in FLUSH.
REQ-031 pc_reg SHALL force bits[1:0] to 0 on every load from pred_pc, redirect_pc or RESET_PC.
REQ-032 inst_valid SHALL be 1 only in VALID; discarded responses SHALL never reach inst.
REQ-033 imem_ack outside FETCH/FLUSH SHALL be ignored.

Reset
REQ-034 While rst_n=0: state=IDLE, pc_reg=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC.
REQ-035 Reset assertion mid-transaction SHALL abort immediately; a later stray ack SHALL be ignored (REQ-033).

Verification
REQ-036 Reset release, ack 2 cycles after req, rdata=32'h00500093, pred_pc=4 -> imem_addr=0; inst_valid=1 with inst_pc=0, pc_nb=4; next req addr=4.
REQ-037 VALID with stall=1 for 3 cycles -> inst/inst_pc stable and imem_req=0 throughout; fetch of pred_pc starts after stall drops.
REQ-038 redirect=1, redirect_pc=32'h100 while in VALID with stall=1 -> inst_valid=0 next cycle; next imem_addr=32'h100.
REQ-039 redirect_pc=32'h200 during outstanding req at 32'h8, ack 3 cycles later -> addr 32'h8 held until ack, data dropped, then req at 32'h200.
REQ-040 Two redirects (32'h40, then 32'h80) in FLUSH -> after ack, only 32'h80 is fetched.
REQ-041 redirect_pc=32'h103, and inst_pc=32'hFFFF_FFFC -> imem_addr=32'h100; pc_nb=32'h0000_0000.
